stage4_message_dispatch: RTL and testbench

Upstream neighbour of the stage-5 field extractors. Accepts a stream of decoded market messages over a valid/ready handshake, classifies each by its type byte, and groups up to three messages into the lanes `message_1..3` with per-lane `message_mux_control_m1..3`. Emits the batch with a `message_en` strobe when three slots are filled or a batch timeout expires. Every stage-5 `*_module` (V4 and siblings) consumes these outputs directly and combinationally.

---
 rtl/stage4_message_dispatch.sv | 194 +++++++++++++++++++
 tb/tb_stage4_message_dispatch.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage4_message_dispatch.sv
// Groups up to three classified market messages into lanes for the stage-5 extractors.
// Build option: define STAGE4_TYPE_FILTER_EN to discard unknown-type messages and count them.
`ifndef MAX_MESSAGE_BITS
`define MAX_MESSAGE_BITS 64
`endif
`ifndef MESSAGE_MUX_CONTROL_WIDTH
`define MESSAGE_MUX_CONTROL_WIDTH 2
`endif
`ifndef MESSAGE_MUX_A
`define MESSAGE_MUX_A 1
`endif
`ifndef MESSAGE_MUX_B
`define MESSAGE_MUX_B 2
`endif

module stage4_message_dispatch #(
    parameter int MSG_BITS = `MAX_MESSAGE_BITS,
    parameter int CTRL_W   = `MESSAGE_MUX_CONTROL_WIDTH,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [MSG_BITS-1:0] in_data,
    output logic                in_ready,
    input  logic                stall,
    output logic                message_en,
    output logic [MSG_BITS-1:0] message_1,
    output logic [MSG_BITS-1:0] message_2,
    output logic [MSG_BITS-1:0] message_3,
    output logic [CTRL_W-1:0]   message_mux_control_m1,
    output logic [CTRL_W-1:0]   message_mux_control_m2,
    output logic [CTRL_W-1:0]   message_mux_control_m3,
    output logic [15:0]         drop_count
);

    localparam logic [CTRL_W-1:0] CODE_A = CTRL_W'(`MESSAGE_MUX_A);
    localparam logic [CTRL_W-1:0] CODE_B = CTRL_W'(`MESSAGE_MUX_B);
    localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [1:0]          fill_q, fill_d;
    logic                in_ready_q, in_ready_d;
    logic [MSG_BITS-1:0] slot_data_q [3];
    logic [MSG_BITS-1:0] slot_data_d [3];
    logic [CTRL_W-1:0]   slot_ctrl_q [3];
    logic [CTRL_W-1:0]   slot_ctrl_d [3];
    logic [MSG_BITS-1:0] out_data_q [3];
    logic [MSG_BITS-1:0] out_data_d [3];
    logic [CTRL_W-1:0]   out_ctrl_q [3];
    logic [CTRL_W-1:0]   out_ctrl_d [3];

    logic [7:0]          in_type;
    logic [CTRL_W-1:0]   in_ctrl;
    logic                accept;
    logic                take;

    assign in_type = in_data[MSG_BITS-1 -: 8];
    assign accept  = in_valid && in_ready_q;

    always_comb begin
        in_ctrl = '0;
        if (in_type == 8'h41) begin
            in_ctrl = CODE_A;
        end else if (in_type == 8'h42) begin
            in_ctrl = CODE_B;
        end
    end

`ifdef STAGE4_TYPE_FILTER_EN
    logic        drop;
    logic [15:0] drop_count_q, drop_count_d;

    assign take = accept && (in_ctrl != '0);
    assign drop = accept && (in_ctrl == '0);

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign take       = accept;
    assign drop_count = '0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        slot_data_d = slot_data_q;
        slot_ctrl_d = slot_ctrl_q;
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;

        // Slots fill strictly in order; fill_q names the next free slot.
        if (take) begin
            for (int i = 0; i < 3; i++) begin
                if (fill_q == 2'(i)) begin
                    slot_data_d[i] = in_data;
                    slot_ctrl_d[i] = in_ctrl;
                end
            end
            fill_d = fill_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    cnt_d   = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // A message accepted on the timeout cycle still rides in this batch.
                if ((fill_d == 2'd3) || (cnt_q == CNT_LAST)) begin
                    state_d    = S_EMIT;
                    out_data_d = slot_data_d;
                    out_ctrl_d = slot_ctrl_d;
                    cnt_d      = '0;
                    fill_d     = '0;
                    for (int i = 0; i < 3; i++) begin
                        slot_data_d[i] = '0;
                        slot_ctrl_d[i] = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EMIT: begin
                if (!stall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d != S_EMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            fill_q     <= '0;
            in_ready_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                slot_data_q[i] <= '0;
                slot_ctrl_q[i] <= '0;
                out_data_q[i]  <= '0;
                out_ctrl_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            in_ready_q  <= in_ready_d;
            slot_data_q <= slot_data_d;
            slot_ctrl_q <= slot_ctrl_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
        end
    end

    assign in_ready               = in_ready_q;
    assign message_en             = (state_q == S_EMIT);
    assign message_1              = out_data_q[0];
    assign message_2              = out_data_q[1];
    assign message_3              = out_data_q[2];
    assign message_mux_control_m1 = out_ctrl_q[0];
    assign message_mux_control_m2 = out_ctrl_q[1];
    assign message_mux_control_m3 = out_ctrl_q[2];

endmodule

// File: tb/tb_stage4_message_dispatch.sv
// Self-checking bench for stage4_message_dispatch: directed scenarios plus a randomized run
// against a batch-level reference model (elapsed time since first message, message list).
`timescale 1ns/1ps
`ifndef MESSAGE_MUX_A
`define MESSAGE_MUX_A 1
`endif
`ifndef MESSAGE_MUX_B
`define MESSAGE_MUX_B 2
`endif

module tb_stage4_message_dispatch;

    localparam int W  = 64;
    localparam int CW = 2;
    localparam int TO = 16;
    localparam logic [CW-1:0] CA = CW'(`MESSAGE_MUX_A);
    localparam logic [CW-1:0] CB = CW'(`MESSAGE_MUX_B);
`ifdef STAGE4_TYPE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          stall = 1'b0;
    logic          in_ready;
    logic          message_en;
    logic [W-1:0]  message_1, message_2, message_3;
    logic [CW-1:0] message_mux_control_m1, message_mux_control_m2, message_mux_control_m3;
    logic [15:0]   drop_count;

    int total = 0;
    int bad   = 0;

    stage4_message_dispatch #(.MSG_BITS(W), .CTRL_W(CW), .TIMEOUT(TO)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .in_data                (in_data),
        .in_ready               (in_ready),
        .stall                  (stall),
        .message_en             (message_en),
        .message_1              (message_1),
        .message_2              (message_2),
        .message_3              (message_3),
        .message_mux_control_m1 (message_mux_control_m1),
        .message_mux_control_m2 (message_mux_control_m2),
        .message_mux_control_m3 (message_mux_control_m3),
        .drop_count             (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: pending message list, edge of first message, emitted batch.
    bit            m_emit = 1'b0;
    int            m_n = 0;
    logic [W-1:0]  m_pd [3];
    logic [CW-1:0] m_pc [3];
    longint        m_first = 0;
    longint        m_edge = 0;
    logic [W-1:0]  e_d [3] = '{default: '0};
    logic [CW-1:0] e_c [3] = '{default: '0};
    int            e_drop = 0;
    bit            e_ready = 1'b0;

    function automatic logic [CW-1:0] cls(input logic [W-1:0] d);
        if (d[W-1 -: 8] == 8'h41) return CA;
        if (d[W-1 -: 8] == 8'h42) return CB;
        return '0;
    endfunction

    function automatic logic [W-1:0] mk(input logic [7:0] t);
        return {t, $urandom(), 24'($urandom())};
    endfunction

    task automatic tick();
        bit            v = in_valid;
        bit            s = stall;
        bit            r = rst_n;
        logic [W-1:0]  d = in_data;
        bit            was_pending;
        logic [CW-1:0] c;
        @(posedge clk);
        m_edge++;
        if (!r) begin
            m_emit  = 1'b0;
            m_n     = 0;
            e_drop  = 0;
            e_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                e_d[i] = '0;
                e_c[i] = '0;
            end
        end else begin
            if (m_emit) begin
                if (!s) m_emit = 1'b0;
            end else begin
                was_pending = (m_n > 0);
                if (v && e_ready) begin
                    c = cls(d);
                    if (FILT && c == '0) begin
                        if (e_drop < 65535) e_drop++;
                    end else begin
                        m_pd[m_n] = d;
                        m_pc[m_n] = c;
                        m_n++;
                        if (!was_pending) m_first = m_edge;
                    end
                end
                if (was_pending && (m_n == 3 || (m_edge - m_first) == longint'(TO))) begin
                    for (int i = 0; i < 3; i++) begin
                        e_d[i] = (i < m_n) ? m_pd[i] : '0;
                        e_c[i] = (i < m_n) ? m_pc[i] : '0;
                    end
                    m_n    = 0;
                    m_emit = 1'b1;
                end
            end
            e_ready = !m_emit;
        end
        #1;
    endtask

    task automatic send_wait(input logic [W-1:0] d, output bit ok);
        bit rb;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20; k++) begin
            rb = in_ready;
            tick();
            if (rb) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = mk(8'h41);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (in_ready !== 1'b0 || message_en !== 1'b0 || message_1 !== '0 || message_2 !== '0 ||
                message_3 !== '0 || message_mux_control_m1 !== '0 || message_mux_control_m2 !== '0 ||
                message_mux_control_m3 !== '0 || drop_count !== '0) begin
                bad++;
                $display("FAIL reset_hold: ready=%b en=%b m1=%h drop=%0d, want all 0",
                         in_ready, message_en, message_1, drop_count);
            end
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || message_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b en=%b, want ready=1 en=0", in_ready, message_en);
        end
    endtask

    task automatic test_full_batch();
        logic [W-1:0] d [3];
        d[0] = mk(8'h41);
        d[1] = mk(8'h42);
        d[2] = mk(8'h41);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = d[k];
            tick();
            total++;
            if (message_en !== (k == 2)) begin
                bad++;
                $display("FAIL full_en_k%0d: en=%b want %b", k, message_en, (k == 2));
            end
        end
        in_valid = 1'b0;
        total++;
        if (message_mux_control_m1 !== CA || message_mux_control_m2 !== CB || message_mux_control_m3 !== CA) begin
            bad++;
            $display("FAIL full_ctrl: got %0d %0d %0d want %0d %0d %0d", message_mux_control_m1,
                     message_mux_control_m2, message_mux_control_m3, CA, CB, CA);
        end
        total++;
        if (message_1 !== d[0] || message_2 !== d[1] || message_3 !== d[2]) begin
            bad++;
            $display("FAIL full_data: got %h %h %h want %h %h %h", message_1, message_2, message_3,
                     d[0], d[1], d[2]);
        end
        $display("batch full: ctrl=%0d,%0d,%0d", message_mux_control_m1, message_mux_control_m2,
                 message_mux_control_m3);
        tick();
        total++;
        if (message_en !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_after: en=%b ready=%b want en=0 ready=1", message_en, in_ready);
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] d;
        d        = mk(8'h41);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < TO; k++) begin
            tick();
            total++;
            if (message_en !== 1'b0) begin
                bad++;
                $display("FAIL timeout_early_%0d: en=%b want 0", k, message_en);
            end
        end
        tick();
        total++;
        if (message_en !== 1'b1 || message_1 !== d || message_2 !== '0 || message_3 !== '0 ||
            message_mux_control_m1 !== CA || message_mux_control_m2 !== '0 || message_mux_control_m3 !== '0) begin
            bad++;
            $display("FAIL timeout_batch: en=%b m1=%h m2=%h m3=%h c=%0d,%0d,%0d want 1 %h 0 0 %0d,0,0",
                     message_en, message_1, message_2, message_3, message_mux_control_m1,
                     message_mux_control_m2, message_mux_control_m3, d, CA);
        end
        $display("batch timeout: m1=%h", message_1);
        tick();
    endtask

    task automatic test_stall();
        logic [W-1:0] s1, s2, s3;
        stall    = 1'b1;
        in_valid = 1'b1;
        in_data  = mk(8'h42);
        tick();
        in_data  = mk(8'h41);
        tick();
        in_data  = mk(8'h42);
        tick();
        s1 = message_1;
        s2 = message_2;
        s3 = message_3;
        in_data = mk(8'h41);
        total++;
        if (message_en !== 1'b1) begin
            bad++;
            $display("FAIL stall_start: en=%b want 1", message_en);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (message_en !== 1'b1 || in_ready !== 1'b0 || message_1 !== s1 || message_2 !== s2 ||
                message_3 !== s3 || message_mux_control_m1 !== CB || message_mux_control_m2 !== CA) begin
                bad++;
                $display("FAIL stall_hold_%0d: en=%b ready=%b m1=%h want 1 0 %h", k, message_en,
                         in_ready, message_1, s1);
            end
        end
        in_valid = 1'b0;
        stall    = 1'b0;
        tick();
        total++;
        if (message_en !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: en=%b ready=%b want 0 1", message_en, in_ready);
        end
        $display("batch stall: released after 6 cycles of en");
    endtask

    task automatic test_timeout_collision();
        logic [W-1:0] d0, d1;
        d0       = mk(8'h42);
        d1       = mk(8'h41);
        in_valid = 1'b1;
        in_data  = d0;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < TO; k++) begin
            tick();
            total++;
            if (message_en !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL collide_wait_%0d: en=%b ready=%b want 0 1", k, message_en, in_ready);
            end
        end
        in_valid = 1'b1;
        in_data  = d1;
        tick();
        in_valid = 1'b0;
        total++;
        if (message_en !== 1'b1 || message_1 !== d0 || message_2 !== d1 || message_3 !== '0 ||
            message_mux_control_m1 !== CB || message_mux_control_m2 !== CA || message_mux_control_m3 !== '0) begin
            bad++;
            $display("FAIL collide_batch: en=%b m1=%h m2=%h c=%0d,%0d,%0d want 1 %h %h %0d,%0d,0",
                     message_en, message_1, message_2, message_mux_control_m1, message_mux_control_m2,
                     message_mux_control_m3, d0, d1, CB, CA);
        end
        $display("batch collision: m2=%h", message_2);
        tick();
    endtask

    task automatic test_filter();
        logic [W-1:0] d [5];
        bit           ok;
        bit           seen;
        d[0] = mk(8'h7F);
        d[1] = mk(8'h41);
        d[2] = mk(8'h7F);
        d[3] = mk(8'h42);
        d[4] = mk(8'h41);
`ifdef STAGE4_TYPE_FILTER_EN
        for (int k = 0; k < 5; k++) begin
            send_wait(d[k], ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL filter_send_%0d: accepted=0 want 1", k);
            end
        end
        total++;
        if (message_en !== 1'b1 || message_mux_control_m1 !== CA || message_mux_control_m2 !== CB ||
            message_mux_control_m3 !== CA || message_1 !== d[1] || message_3 !== d[4]) begin
            bad++;
            $display("FAIL filter_batch: en=%b c=%0d,%0d,%0d want 1 %0d,%0d,%0d", message_en,
                     message_mux_control_m1, message_mux_control_m2, message_mux_control_m3, CA, CB, CA);
        end
        total++;
        if (drop_count !== 16'd2) begin
            bad++;
            $display("FAIL filter_drops: drop_count=%0d want 2", drop_count);
        end
        tick();
`else
        for (int k = 0; k < 3; k++) begin
            send_wait(d[k], ok);
        end
        total++;
        if (message_en !== 1'b1 || message_mux_control_m1 !== '0 || message_mux_control_m2 !== CA ||
            message_mux_control_m3 !== '0 || message_1 !== d[0] || message_3 !== d[2]) begin
            bad++;
            $display("FAIL nofilter_batch1: en=%b c=%0d,%0d,%0d want 1 0,%0d,0", message_en,
                     message_mux_control_m1, message_mux_control_m2, message_mux_control_m3, CA);
        end
        send_wait(d[3], ok);
        send_wait(d[4], ok);
        seen = 1'b0;
        for (int k = 0; k < 3 * TO && !seen; k++) begin
            if (message_en === 1'b1) begin
                seen = 1'b1;
            end else begin
                tick();
            end
        end
        total++;
        if (!seen || message_mux_control_m1 !== CB || message_mux_control_m2 !== CA ||
            message_mux_control_m3 !== '0 || message_1 !== d[3]) begin
            bad++;
            $display("FAIL nofilter_batch2: seen=%b c=%0d,%0d,%0d want 1 %0d,%0d,0", seen,
                     message_mux_control_m1, message_mux_control_m2, message_mux_control_m3, CB, CA);
        end
        total++;
        if (drop_count !== 16'd0) begin
            bad++;
            $display("FAIL nofilter_drops: drop_count=%0d want 0", drop_count);
        end
        tick();
`endif
        $display("batch filter: drop_count=%0d", drop_count);
    endtask

    task automatic test_random();
        logic [7:0] t;
        bit         prev_en = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            in_valid = ($urandom_range(0, 99) < 55);
            stall    = ($urandom_range(0, 99) < 35);
            case ($urandom_range(0, 3))
                0: t = 8'h41;
                1: t = 8'h42;
                2: t = 8'h7F;
                default: t = 8'($urandom());
            endcase
            in_data = mk(t);
            tick();
            total++;
            if (in_ready !== e_ready || message_en !== m_emit || drop_count !== 16'(e_drop)) begin
                bad++;
                $display("FAIL rand_ctl_%0d: ready=%b en=%b drop=%0d want %b %b %0d", n, in_ready,
                         message_en, drop_count, e_ready, m_emit, e_drop);
            end
            total++;
            if (message_1 !== e_d[0] || message_2 !== e_d[1] || message_3 !== e_d[2] ||
                message_mux_control_m1 !== e_c[0] || message_mux_control_m2 !== e_c[1] ||
                message_mux_control_m3 !== e_c[2]) begin
                bad++;
                $display("FAIL rand_lanes_%0d: c=%0d,%0d,%0d m1=%h want %0d,%0d,%0d %h", n,
                         message_mux_control_m1, message_mux_control_m2, message_mux_control_m3,
                         message_1, e_c[0], e_c[1], e_c[2], e_d[0]);
            end
            if (message_en && !prev_en) begin
                $display("batch random cycle %0d: ctrl=%0d,%0d,%0d", n, message_mux_control_m1,
                         message_mux_control_m2, message_mux_control_m3);
            end
            prev_en = message_en;
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        stall    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_batch();
        test_timeout();
        test_stall();
        test_timeout_collision();
        test_filter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
